// File: rtl/reg_file_param.sv
// Parametrised general-purpose register file for the 32-bit RISC core.
// Two combinational read ports with an optional write-first bypass, one
// write port, and a valid/ready dump engine that streams every register
// out in index order while normal pipeline access continues.

module reg_file_param #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 4,
    parameter int                SP_IDX   = 14,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h1000,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] D1,
    output logic [DATA_W-1:0] D2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] D3,
    input  logic              IsWb,
    input  logic              DumpStart,
    input  logic              DumpReady,
    output logic              DumpValid,
    output logic [ADDR_W-1:0] DumpIdx,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpBusy,
    output logic              DumpDone
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        STREAM
    } dumpState_t;

    logic [DATA_W-1:0] regQ [DEPTH];

    dumpState_t        stateQ, stateD;
    logic [ADDR_W-1:0] idxQ, idxD;
    logic [DATA_W-1:0] dataQ, dataD;
    logic              doneQ, doneD;

    logic [ADDR_W-1:0] snapIdx;
    logic [DATA_W-1:0] snapData;

    // Register array: reset loads zeros plus the stack-pointer seed; a write
    // commits at the rising edge and is blocked while reset is held.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regQ[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (IsWb) begin
            regQ[A3] <= D3;
        end
    end

    // Read ports: stored contents, optionally overridden by the in-flight
    // write so decode sees a same-cycle result; no forwarding during reset.
    always_comb begin
        D1 = regQ[A1];
        D2 = regQ[A2];
        if (BYPASS && !Reset && IsWb && (A3 == A1)) begin
            D1 = D3;
        end
        if (BYPASS && !Reset && IsWb && (A3 == A2)) begin
            D2 = D3;
        end
    end

    // Snapshot of the next word to issue, taken write-first so a word equals
    // what the register holds after this edge; independent of BYPASS.
    always_comb begin
        snapIdx  = (stateQ == STREAM) ? idxQ + ADDR_W'(1) : '0;
        snapData = (IsWb && (A3 == snapIdx)) ? D3 : regQ[snapIdx];
    end

    // Dump next-state: start from IDLE, advance on each handshake, and leave
    // through IDLE with a one-cycle done pulse after the last index.
    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        dataD  = dataQ;
        doneD  = 1'b0;
        case (stateQ)
            IDLE: begin
                if (DumpStart) begin
                    stateD = STREAM;
                    idxD   = '0;
                    dataD  = snapData;
                end
            end
            STREAM: begin
                if (DumpReady) begin
                    if (idxQ == '1) begin
                        stateD = IDLE;
                        doneD  = 1'b1;
                    end else begin
                        idxD  = snapIdx;
                        dataD = snapData;
                    end
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Dump state and registered outputs; reset aborts a dump without a done pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateQ <= IDLE;
            idxQ   <= '0;
            dataQ  <= '0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
            dataQ  <= dataD;
            doneQ  <= doneD;
        end
    end

    assign DumpValid = (stateQ == STREAM);
    assign DumpBusy  = (stateQ == STREAM);
    assign DumpIdx   = idxQ;
    assign DumpData  = dataQ;
    assign DumpDone  = doneQ;

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised general-purpose register file for the 32-bit RISC core. It succeeds the fixed 16×32 register file. Depth and width are configurable, and reads are fully combinational with an optional write-first bypass, so the decode stage sees a result written in the same cycle. A valid/ready dump engine streams every register out in index order, for context save and for debug or trace capture, while normal pipeline access continues.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 4: address width; depth is 2^ADDR_W registers.
- SP_IDX, 14: index of the stack-pointer register.
- SP_RESET, 32'h1000: reset value of R[SP_IDX]. All other registers reset to 0.
- BYPASS, 1: 1 enables the write-to-read forward; 0 makes reads return stored contents only.

Ports:
- Clk  in  1  single clock. All state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- A1  in  ADDR_W  read port 1 address.
- A2  in  ADDR_W  read port 2 address.
- D1  out  DATA_W  read port 1 data.
- D2  out  DATA_W  read port 2 data.
- A3  in  ADDR_W  write address.
- D3  in  DATA_W  write data.
- IsWb  in  1  write enable. Commits D3 to R[A3] at the rising edge.
- DumpStart  in  1  single-cycle request to begin a dump.
- DumpReady  in  1  consumer accepts the current dump word.
- DumpValid  out  1  DumpIdx/DumpData are valid.
- DumpIdx  out  ADDR_W  index of the presented register.
- DumpData  out  DATA_W  captured register value.
- DumpBusy  out  1  dump in progress.
- DumpDone  out  1  one-cycle pulse after the final word is accepted.

## Operation
- Reset (asynchronous, immediate):
  - every R[i] becomes 0, except R[SP_IDX] = SP_RESET;
  - the dump FSM goes to IDLE;
  - DumpValid, DumpBusy and DumpDone go to 0, and DumpIdx and DumpData go to 0;
  - writes are blocked while Reset is high.
- Write:
  - at the rising edge with IsWb=1 and Reset=0, R[A3] <= D3;
  - there is no hard-wired zero register, so every index is writable.
- Read:
  - D1 = (BYPASS && IsWb && A3==A1) ? D3 : R[A1];
  - D2 behaves the same way with A2;
  - reads are purely combinational, with no clock-phase gating;
  - during reset, D1/D2 show the reset contents at the addressed index.
- Dump FSM, state IDLE:
  - DumpBusy=0 and DumpValid=0;
  - DumpStart=1 at an edge moves the FSM to STREAM with DumpIdx=0;
  - DumpData is loaded with the write-first value of R[0], i.e. D3 if IsWb && A3==0 at that same edge, else R[0].
- Dump FSM, state STREAM:
  - DumpBusy=1 and DumpValid=1;
  - a handshake is DumpValid && DumpReady at an edge;
  - on a handshake with DumpIdx < 2^ADDR_W−1, DumpIdx increments and DumpData loads the write-first value of the new index, using the same rule;
  - on a handshake with DumpIdx = 2^ADDR_W−1, the FSM returns to IDLE and DumpDone=1 for exactly one cycle.
- Backpressure: while DumpValid && !DumpReady, DumpIdx and DumpData hold stable. This holds even if the presented register is rewritten, because each word is a snapshot taken when it is issued.
- DumpStart is ignored while DumpBusy=1. It is honoured in the DumpDone cycle (the FSM is already in IDLE).
- Writes during a dump are always committed:
  - a register with an index below the current DumpIdx is not re-dumped;
  - a register at a higher index is dumped with its newer value.

## Timing
- Read latency: 0 cycles (combinational). A write at edge N is visible from stored contents after edge N, and through the bypass before edge N.
- Dump latency:
  - DumpStart sampled at edge N gives DumpValid=1 after edge N;
  - with DumpReady held at 1, word k is presented after edge N+k;
  - the last handshake is at edge N+2^ADDR_W;
  - DumpDone is high after that edge, for one cycle;
  - a full dump takes 2^ADDR_W cycles minimum.
- DumpIdx wraps from 2^ADDR_W−1 back to 0 only through IDLE.
- Reset asserted mid-dump aborts the dump immediately. No DumpDone pulse is produced and all outputs return to their reset values.

## Test plan
- Reset, then read A1=14 and A2=3: D1=32'h1000 and D2=0. Assert Reset during an active write: no register changes.
- IsWb=1, A3=5, D3=32'hDEADBEEF, A1=5, same cycle:
  - D1=DEADBEEF before the edge with BYPASS=1;
  - D1=0 before the edge with BYPASS=0;
  - D1=DEADBEEF after the edge in both cases.
- Load R[i]=i*16'h0101, then DumpStart with DumpReady held at 1: 16 words, indices 0..15, matching data, DumpDone pulses one cycle after index 15, and the total is 16 cycles.
- Dump with DumpReady toggling 1-0-0-1 while writing R[DumpIdx] during the stall: DumpIdx and DumpData hold the pre-write snapshot, and the following word is correct.
- During a dump presenting index 3, write R[2]=AA and R[9]=BB: index 9 dumps BB, and index 2 is not re-emitted. A DumpStart pulsed mid-dump is ignored.
- Assert Reset at DumpIdx=7: DumpValid, DumpBusy and DumpIdx are 0 immediately, no DumpDone follows, and a new DumpStart after release restarts at index 0.
